// File: rtl/banco_reg_mips.sv
// banco_reg_mips: 32 x 32-bit MIPS general-purpose register file for the
// multicycle datapath. It has two combinational read ports and one write
// port that updates on the rising clock edge.
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all registers, loads $sp
//   RegWrite   write enable, sampled on rising clk
//   ReadReg1   read port 1 index
//   ReadReg2   read port 2 index
//   WriteReg   write index (rt, rd, $29 or $31 from the select mux)
//   WriteData  write data
//   ReadData1  contents of ReadReg1 ($0 always reads 0)
//   ReadData2  contents of ReadReg2 ($0 always reads 0)
module banco_reg_mips #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SP_INDEX = 29,
    parameter int unsigned SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Storage. Entry 0 is held at zero and never written, so $0 cannot
    // leak a written value even if the read masking were bypassed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == int'(SP_INDEX))
                    regs[i] <= DATA_W'(SP_RESET);
                else
                    regs[i] <= '0;
            end
        end else if (RegWrite && (WriteReg != '0)) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Combinational read ports with no write bypass; the FSM never reads
    // and writes the same register in one cycle.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != '0)
            ReadData1 = regs[ReadReg1];
        if (ReadReg2 != '0)
            ReadData2 = regs[ReadReg2];
    end

endmodule

// File: tb/tb_banco_reg_mips.sv
// Directed self-checking bench for banco_reg_mips.
module tb_banco_reg_mips;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int errors = 0;

    banco_reg_mips dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drive a write after the falling edge, let one rising edge take it.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = addr;
        WriteData = data;
        @(posedge clk);
        #1;
        RegWrite  = 1'b0;
    endtask

    function automatic logic [31:0] reset_val(input int idx);
        return (idx == 29) ? 32'd227 : 32'd0;
    endfunction

    // Sweep all indices on both ports against the reset contents.
    task automatic check_reset_image(input string tag);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check({tag, "_p1"}, ReadData1, reset_val(i));
            check({tag, "_p2"}, ReadData2, reset_val(31 - i));
        end
    endtask

    initial begin
        reset     = 1'b1;
        RegWrite  = 1'b0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        WriteReg  = '0;
        WriteData = '0;

        // Reset contents visible while reset is held
        #2;
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd31;
        #1;
        check("rst_sp", ReadData1, 32'd227);
        check("rst_ra", ReadData2, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_sp", ReadData1, 32'd227);

        // Write $8; old value before the edge, new value after
        @(negedge clk);
        ReadReg1  = 5'd8;
        RegWrite  = 1'b1;
        WriteReg  = 5'd8;
        WriteData = 32'hDEADBEEF;
        #1;
        check("r8_before_edge", ReadData1, 32'd0);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        check("r8_after_edge", ReadData1, 32'hDEADBEEF);

        // Write to $0 is discarded
        do_write(5'd0, 32'hFFFFFFFF);
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        #1;
        check("r0_p1", ReadData1, 32'd0);
        check("r0_p2", ReadData2, 32'd0);

        // RegWrite=0 changes nothing over several edges
        @(negedge clk);
        RegWrite  = 1'b0;
        WriteReg  = 5'd5;
        WriteData = 32'h12345678;
        ReadReg2  = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        check("r5_no_we", ReadData2, 32'd0);

        // $31 and $29 on consecutive edges, read together
        do_write(5'd31, 32'h00000040);
        do_write(5'd29, 32'h000000E0);
        ReadReg1 = 5'd31;
        ReadReg2 = 5'd29;
        #1;
        check("ra_written", ReadData1, 32'h00000040);
        check("sp_written", ReadData2, 32'h000000E0);

        // Both ports on one register
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd8;
        #1;
        check("same_p1", ReadData1, 32'hDEADBEEF);
        check("same_p2", ReadData2, 32'hDEADBEEF);

        // More writes, then reset mid-run with a pending write
        do_write(5'd3,  32'hA5A5A5A5);
        do_write(5'd20, 32'h0BADF00D);
        do_write(5'd12, 32'h00000055);
        ReadReg1 = 5'd12;
        #1;
        check("r12_pre", ReadData1, 32'h00000055);

        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd12;
        WriteData = 32'd7;
        #2;
        reset = 1'b1;
        #1;
        check("r12_rst_immediate", ReadData1, 32'd0);
        @(posedge clk);
        #1;
        check("r12_rst_edge", ReadData1, 32'd0);
        check_reset_image("rst_hold");

        // Release with RegWrite low: no write on the following edge
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check_reset_image("rst_release");

        // $sp writable again after reset
        do_write(5'd29, 32'h00001000);
        ReadReg1 = 5'd29;
        #1;
        check("sp_rewrite", ReadData1, 32'h00001000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
